// File: rtl/sigma_dpe_sequencer.sv
// Job-level sequencer in front of flexdpe: takes one GEMM-tile descriptor, feeds one
// stationary beat and N streaming beats, waits out the reduction pipeline, then pulses done.
module sigma_dpe_sequencer #(
  parameter int IN_DATA_TYPE = 16,
  parameter int NUM_PES      = 32,
  parameter int LOG2_PES     = 5,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [NUM_PES*LOG2_PES-1:0]      cfg_stat_dest,
  input  logic [NUM_PES*LOG2_PES-1:0]      cfg_strm_dest,
  input  logic [NUM_PES*LOG2_PES-1:0]      cfg_vn_sep,
  input  logic [CNT_W-1:0]                 cfg_num_stream,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PES*IN_DATA_TYPE-1:0]  in_data,
  output logic                             dpe_data_valid,
  output logic                             dpe_stationary,
  output logic [NUM_PES*IN_DATA_TYPE-1:0]  dpe_data_bus,
  output logic [NUM_PES*LOG2_PES-1:0]      dpe_dest_bus,
  output logic [NUM_PES*LOG2_PES-1:0]      dpe_vn_seperator,
  input  logic [NUM_PES-1:0]               dpe_o_valid,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 result_cnt
);

  localparam int MAP_W   = NUM_PES * LOG2_PES;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_STAT, STREAM, DRAIN, DONE} state_t;

  state_t               state, next_state;
  logic [MAP_W-1:0]     stat_dest, strm_dest, vn_sep;
  logic [CNT_W-1:0]     num_stream, beat_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 cfg_fire, in_fire, last_beat;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_beat = ({1'b0, beat_cnt} + (CNT_W+1)'(1)) == {1'b0, num_stream};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cfg_valid) next_state = LOAD_STAT;
      LOAD_STAT: if (in_valid)  next_state = (num_stream == '0) ? DRAIN : STREAM;
      STREAM:    if (in_valid && last_beat) next_state = DRAIN;
      DRAIN:     if (drain_cnt == '0) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Handshake readiness depends on state only, never on the valid it qualifies.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:              cfg_ready = 1'b1;
      LOAD_STAT, STREAM: in_ready  = 1'b1;
      DONE:              done      = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the held descriptor is reset as well, so a job dropped by reset leaves nothing
  // behind that a later job could pick up by mistake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_dest  <= '0;
      strm_dest  <= '0;
      vn_sep     <= '0;
      num_stream <= '0;
    end else if (cfg_fire) begin
      stat_dest  <= cfg_stat_dest;
      strm_dest  <= cfg_strm_dest;
      vn_sep     <= cfg_vn_sep;
      num_stream <= cfg_num_stream;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                          beat_cnt <= '0;
    else if (cfg_fire)                 beat_cnt <= '0;
    else if (in_fire && state == STREAM) beat_cnt <= beat_cnt + CNT_W'(1);
  end

  // Preloaded outside DRAIN so the count is already DRAIN_CYCLES-1 on the first drain cycle.
  always_ff @(posedge clk) begin
    if (!rst)                  drain_cnt <= '0;
    else if (state != DRAIN)   drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
    else if (drain_cnt != '0)  drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dpe_data_valid   <= 1'b0;
      dpe_stationary   <= 1'b0;
      dpe_data_bus     <= '0;
      dpe_dest_bus     <= '0;
      dpe_vn_seperator <= '0;
    end else if (in_fire) begin
      dpe_data_valid   <= 1'b1;
      dpe_stationary   <= (state == LOAD_STAT);
      dpe_data_bus     <= in_data;
      dpe_dest_bus     <= (state == LOAD_STAT) ? stat_dest : strm_dest;
      dpe_vn_seperator <= (state == LOAD_STAT) ? '0 : vn_sep;
    end else begin
      dpe_data_valid   <= 1'b0;
      dpe_stationary   <= 1'b0;
      dpe_data_bus     <= '0;
      dpe_dest_bus     <= '0;
      dpe_vn_seperator <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)               busy <= 1'b0;
    else if (cfg_fire)      busy <= 1'b1;
    else if (state == DONE) busy <= 1'b0;
  end

  // Result counter holds through IDLE so software can read it after done.
  always_ff @(posedge clk) begin
    if (!rst)
      result_cnt <= '0;
    else if (cfg_fire)
      result_cnt <= '0;
    else if (state != IDLE && (|dpe_o_valid) && result_cnt != '1)
      result_cnt <= result_cnt + CNT_W'(1);
  end

endmodule
